add8_sched: RTL and testbench
=============================

ADD8_SCHED -- requirements
Module: add8_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 Port: clk  in  1  rising-edge clock for all state.
REQ-003 Port: rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004 Port: req  in  4  per-requester request, level, held until that requester's done.
REQ-005 Port: op_a  in  32  requester k operand A in bits 8k..8k+7, bit 8k = LSB.
REQ-006 Port: op_b  in  32  requester k operand B, same packing as op_a.
REQ-007 Port: gnt  out  4  one-hot, high for the winning requester during OPERATE.
REQ-008 Port: done  out  4  one-hot single-cycle pulse in RESP, marks result/carry valid.
REQ-009 Port: result  out  8  registered sum, bit 0 = LSB.
REQ-010 Port: carry  out  1  registered carry-out of the sum.
REQ-011 Port: busy  out  1  high in OPERATE and RESP.

Function
REQ-012 The block SHALL time-share one internal add8 instance (ripple of add1 cells, carry_in tied 0) among 4 requesters.
REQ-013 The FSM SHALL have states IDLE, OPERATE and RESP, encoded in 2 bits; the unused code SHALL return to IDLE.
REQ-014 IDLE: no req bit set -> stay in IDLE; any req bit set -> latch winner index and its op_a/op_b, then go to OPERATE.
REQ-015 Arbitration SHALL be round-robin: search starts at rr_ptr and ascends mod 4; the first set req bit wins.
REQ-016 OPERATE SHALL last exactly 1 cycle: assert gnt[idx], register adder sum into result and carry-out into carry, then go to RESP.
REQ-017 RESP SHALL last exactly 1 cycle: assert done[idx], set rr_ptr <= (idx+1) mod 4, then go to IDLE.
REQ-018 Latency SHALL be: req sampled in IDLE at edge k -> gnt high in cycle k+1 -> done high in cycle k+2; throughput is 1 operation per 3 cycles.
REQ-019 Operands SHALL be captured only on the IDLE->OPERATE edge; later changes to op_a/op_b SHALL NOT affect the result in flight.
REQ-020 Deassertion of req during OPERATE or RESP SHALL NOT abort the transaction; done SHALL still pulse.
REQ-021 A requester whose req stays high after its done SHALL remain eligible, at lowest priority for the next arbitration.
REQ-022 result and carry SHALL hold their value from the last OPERATE until the next OPERATE.
REQ-023 gnt and done SHALL be 0 in every state other than the one named in REQ-016 and REQ-017.
REQ-024 Sum arithmetic: {carry,result} = a + b, modulo 512; 255+1 SHALL yield result=0 and carry=1.

Reset
REQ-025 rst_n low at a clk edge SHALL force state=IDLE, rr_ptr=0, gnt=0, done=0, busy=0, result=0 and carry=0.
REQ-026 A reset during OPERATE or RESP SHALL abort the transaction with no done pulse.
REQ-027 Arbitration SHALL resume on the first edge with rst_n high, starting from requester 0.

Configuration
REQ-028 With macro ADD8_SCHED_SAT_EN defined, any add8 carry-out SHALL force result=255; the carry output still SHALL reflect the true carry.
REQ-029 Without ADD8_SCHED_SAT_EN, result SHALL be the raw modulo-256 sum.

Verification
REQ-030 Reset, then req=0001 with A0=3, B0=4 -> gnt=0001 at k+1; done=0001 at k+2 with result=7, carry=0.
REQ-031 req=1111 held high -> done order 0,1,2,3,0, one done every 3 cycles, no requester starved.
REQ-032 A1=200, B1=100 -> carry=1 with result=44 (macro undefined) or result=255 (ADD8_SCHED_SAT_EN defined).
REQ-033 Change op_a and drop req in the OPERATE cycle -> done still pulses and result uses the originally latched operands.
REQ-034 Assert rst_n low in the OPERATE cycle -> no done pulse, all outputs 0; the next req=0100 is served normally.
REQ-035 Two requesters at once, req=0110 with rr_ptr=2 -> requester 2 wins first, then requester 1.

Source files
------------

// File: rtl/add8_sched.sv
// Four-requester round-robin scheduler sharing one 8-bit ripple adder (3 cycles per operation).
// Optional build macro ADD8_SCHED_SAT_EN: a carry-out saturates result to 255.
module add8_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic [7:0]  result,
  output logic        carry,
  output logic        busy
);

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPERATE = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         idx, idx_nxt;
  logic [IDX_W-1:0]         rr_ptr, rr_ptr_nxt;
  logic [DATA_W-1:0]        opa, opa_nxt;
  logic [DATA_W-1:0]        opb, opb_nxt;
  logic [N_REQ-1:0]         gnt_nxt, done_nxt;
  logic [DATA_W-1:0]        result_nxt;
  logic                     carry_nxt, busy_nxt;

  logic [N_REQ-1:0][DATA_W-1:0] a_vec, b_vec;
  logic [IDX_W-1:0]         win;
  logic                     win_valid;
  logic [DATA_W-1:0]        sum;
  logic [DATA_W:0]          rc;

  assign a_vec = op_a;
  assign b_vec = op_b;

  // Round-robin search: start at rr_ptr, ascend modulo 4, first set request wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    win       = '0;
    win_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = rr_ptr + IDX_W'(i);
      if (!win_valid && req[cand]) begin
        win       = cand;
        win_valid = 1'b1;
      end
    end
  end

  // Shared adder: ripple of full-adder cells, carry-in tied low.
  assign rc[0] = 1'b0;
  for (genvar g = 0; g < DATA_W; g++) begin : g_add1
    assign sum[g]  = opa[g] ^ opb[g] ^ rc[g];
    assign rc[g+1] = (opa[g] & opb[g]) | (rc[g] & (opa[g] ^ opb[g]));
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    rr_ptr_nxt = rr_ptr;
    opa_nxt    = opa;
    opb_nxt    = opb;
    gnt_nxt    = '0;
    done_nxt   = '0;
    busy_nxt   = 1'b0;
    result_nxt = result;
    carry_nxt  = carry;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nxt = OPERATE;
          idx_nxt   = win;
          opa_nxt   = a_vec[win];
          opb_nxt   = b_vec[win];
          gnt_nxt   = N_REQ'(1) << win;
          busy_nxt  = 1'b1;
        end
      end
      OPERATE: begin
        state_nxt = RESP;
`ifdef ADD8_SCHED_SAT_EN
        result_nxt = rc[DATA_W] ? {DATA_W{1'b1}} : sum;
`else
        result_nxt = sum;
`endif
        carry_nxt = rc[DATA_W];
        done_nxt  = N_REQ'(1) << idx;
        busy_nxt  = 1'b1;
      end
      RESP: begin
        state_nxt  = IDLE;
        rr_ptr_nxt = idx + IDX_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs and datapath are registered from the next-state logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      rr_ptr <= '0;
      opa    <= '0;
      opb    <= '0;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
    end else begin
      idx    <= idx_nxt;
      rr_ptr <= rr_ptr_nxt;
      opa    <= opa_nxt;
      opb    <= opb_nxt;
      gnt    <= gnt_nxt;
      done   <= done_nxt;
      busy   <= busy_nxt;
      result <= result_nxt;
      carry  <= carry_nxt;
    end
  end

endmodule

// File: tb/tb_add8_sched.sv
// Directed-vector bench for add8_sched; expected values are hand-computed below.
module tb_add8_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  result;
  logic        carry;
  logic        busy;

  int total = 0;
  int bad   = 0;

  add8_sched dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .op_a   (op_a),
    .op_b   (op_b),
    .gnt    (gnt),
    .done   (done),
    .result (result),
    .carry  (carry),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ADD8_SCHED_SAT_EN
  localparam logic [7:0] RES_200_100 = 8'd255;
  localparam logic [7:0] RES_255_1   = 8'd255;
`else
  localparam logic [7:0] RES_200_100 = 8'd44;
  localparam logic [7:0] RES_255_1   = 8'd0;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [3:0] d,
                            input logic b);
    check_val({tag, ".gnt"},  32'(gnt),  32'(g));
    check_val({tag, ".done"}, 32'(done), 32'(d));
    check_val({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic check_sum(input string tag, input logic [7:0] r, input logic c);
    check_val({tag, ".result"}, 32'(result), 32'(r));
    check_val({tag, ".carry"},  32'(carry),  32'(c));
  endtask

  initial begin
    logic [3:0] exp_idx [5];
    logic [7:0] exp_sum [4];
    exp_idx = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    exp_sum = '{8'd3, 8'd14, 8'd25, 8'd36};

    rst_n = 1'b0;
    req   = 4'b0000;
    op_a  = '0;
    op_b  = '0;
    step();
    step();
    check_outs("reset", 4'b0000, 4'b0000, 1'b0);
    check_sum("reset", 8'd0, 1'b0);

    // Single request: 3 + 4.
    rst_n = 1'b1;
    req   = 4'b0001;
    op_a[7:0] = 8'd3;
    op_b[7:0] = 8'd4;
    step();
    check_outs("basic_op", 4'b0001, 4'b0000, 1'b1);
    step();
    check_outs("basic_resp", 4'b0000, 4'b0001, 1'b1);
    check_sum("basic_resp", 8'd7, 1'b0);
    req = 4'b0000;
    step();
    check_outs("basic_idle", 4'b0000, 4'b0000, 1'b0);

    // Carry case: 200 + 100 (rr_ptr = 1).
    req = 4'b0010;
    op_a[15:8] = 8'd200;
    op_b[15:8] = 8'd100;
    step();
    check_outs("carry_op", 4'b0010, 4'b0000, 1'b1);
    step();
    check_outs("carry_resp", 4'b0000, 4'b0010, 1'b1);
    check_sum("carry_resp", RES_200_100, 1'b1);
    req = 4'b0000;
    step();

    // Two requesters with rr_ptr = 2: requester 2 first, then 1.
    req = 4'b0110;
    op_a[23:16] = 8'd10;
    op_b[23:16] = 8'd20;
    step();
    check_outs("pair_op2", 4'b0100, 4'b0000, 1'b1);
    step();
    check_outs("pair_resp2", 4'b0000, 4'b0100, 1'b1);
    check_sum("pair_resp2", 8'd30, 1'b0);
    req = 4'b0010;
    step();
    check_outs("pair_idle", 4'b0000, 4'b0000, 1'b0);
    step();
    check_outs("pair_op1", 4'b0010, 4'b0000, 1'b1);
    step();
    check_outs("pair_resp1", 4'b0000, 4'b0010, 1'b1);
    check_sum("pair_resp1", RES_200_100, 1'b1);
    req = 4'b0000;
    step();

    // Boundary 255 + 1, then result/carry hold while idle.
    req = 4'b0100;
    op_a[23:16] = 8'd255;
    op_b[23:16] = 8'd1;
    step();
    check_outs("wrap_op", 4'b0100, 4'b0000, 1'b1);
    step();
    check_sum("wrap_resp", RES_255_1, 1'b1);
    req = 4'b0000;
    step();
    step();
    step();
    check_outs("hold", 4'b0000, 4'b0000, 1'b0);
    check_sum("hold", RES_255_1, 1'b1);

    // Operand change and req drop during OPERATE do not disturb the result.
    req = 4'b1000;
    op_a[31:24] = 8'd50;
    op_b[31:24] = 8'd60;
    step();
    check_outs("late_op", 4'b1000, 4'b0000, 1'b1);
    op_a[31:24] = 8'd1;
    req = 4'b0000;
    step();
    check_outs("late_resp", 4'b0000, 4'b1000, 1'b1);
    check_sum("late_resp", 8'd110, 1'b0);
    step();

    // All four requesting: order 0,1,2,3,0, one done per 3 cycles.
    op_a = {8'd31, 8'd21, 8'd11, 8'd1};
    op_b = {8'd5, 8'd4, 8'd3, 8'd2};
    req  = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      check_outs($sformatf("rr%0d_op", n), 4'b0001 << exp_idx[n], 4'b0000, 1'b1);
      step();
      check_outs($sformatf("rr%0d_resp", n), 4'b0000, 4'b0001 << exp_idx[n], 1'b1);
      check_sum($sformatf("rr%0d_resp", n), exp_sum[exp_idx[n][1:0]], 1'b0);
      if (n == 4) req = 4'b0000;
      step();
      check_outs($sformatf("rr%0d_idle", n), 4'b0000, 4'b0000, 1'b0);
    end

    // Reset during OPERATE aborts; next request is served from requester 0 search.
    req = 4'b0010;
    op_a[15:8] = 8'd5;
    op_b[15:8] = 8'd6;
    step();
    check_outs("abort_op", 4'b0010, 4'b0000, 1'b1);
    rst_n = 1'b0;
    step();
    check_outs("abort_rst", 4'b0000, 4'b0000, 1'b0);
    check_sum("abort_rst", 8'd0, 1'b0);
    rst_n = 1'b1;
    req   = 4'b0000;
    step();
    check_outs("abort_nodone", 4'b0000, 4'b0000, 1'b0);
    req = 4'b0100;
    op_a[23:16] = 8'd7;
    op_b[23:16] = 8'd8;
    step();
    check_outs("post_op", 4'b0100, 4'b0000, 1'b1);
    step();
    check_outs("post_resp", 4'b0000, 4'b0100, 1'b1);
    check_sum("post_resp", 8'd15, 1'b0);
    req = 4'b0000;
    step();

    // After reset the pointer restarts at 0: req 1001 grants requester 0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 4'b1001;
    step();
    check_outs("ptr0_op", 4'b0001, 4'b0000, 1'b1);
    step();
    check_outs("ptr0_resp", 4'b0000, 4'b0001, 1'b1);
    check_sum("ptr0_resp", 8'd3, 1'b0);
    req = 4'b0000;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
